// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Purpose:
//   Control unit for a multicycle LEGv8-style datapath. Sequences fetch,
//   decode, address generation, memory access, register execution, write-back
//   and conditional branch (CBZ). A per-state watchdog turns a stalled memory
//   handshake into a sticky fault state, and a 16-bit counter reports the number
//   of completed instructions.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   instr[10:0]  opcode field IR[31:21], valid from DECODE onward
//   zero         ALU zero flag (CBZ condition)
//   mem_ready    completion strobe for the outstanding memory request
//   mem_req      memory request, held until mem_ready
//   memRead      read qualifier (valid with mem_req)
//   memWrite     write qualifier (valid with mem_req)
//   IRWrite      instruction register load
//   PCWrite      program counter load
//   PCSrc        PC source: 0 = PC+4, 1 = branch target
//   reg2loc      register-file read-port-2 address select
//   AluSrc       ALU B operand select: 0 = register, 1 = immediate
//   memtoReg     write-back source: 0 = ALU, 1 = memory
//   regWrite     register-file write enable
//   AluControl   ALU operation
//   state        current state encoding (debug)
//   retired      completed-instruction count, wraps at 16 bits
//   error        fault flag, set while in ERROR (only reset leaves ERROR)
//
// States:
//   state  | code | meaning
//   FETCH  |  0   | instruction read; IR and PC+4 load on mem_ready
//   DECODE |  1   | opcode captured into op_q, dispatch by opcode
//   ADDR   |  2   | effective address = base + offset (LDUR/STUR)
//   MEMACC |  3   | data memory access, wait for mem_ready
//   WB_LD  |  4   | load data written to register file
//   EXEC_R |  5   | R-type ALU operation
//   WB_R   |  6   | R-type result written to register file
//   BRANCH |  7   | CBZ: pass B through ALU, take branch on zero
//   ERROR  |  8   | illegal opcode or memory timeout; reset only
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        memRead,
  output logic        memWrite,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        reg2loc,
  output logic        AluSrc,
  output logic        memtoReg,
  output logic        regWrite,
  output logic [3:0]  AluControl,
  output logic [3:0]  state,
  output logic [15:0] retired,
  output logic        error
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_ADDR   = 4'd2,
    S_MEMACC = 4'd3,
    S_WB_LD  = 4'd4,
    S_EXEC_R = 4'd5,
    S_WB_R   = 4'd6,
    S_BRANCH = 4'd7,
    S_ERROR  = 4'd8
  } state_t;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  // Watchdog fires on the cycle the count reaches TIMEOUT-1, so a request is
  // given exactly TIMEOUT cycles in the waiting state before the fault.
  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wd_q, wd_d;
  logic [15:0] retired_q, retired_d;
  logic [10:0] op_q, op_d;

  logic        op_is_stur;
  logic        op_is_ldur;
  logic [3:0]  alu_r;
  logic        retire;

  // Later states work from the opcode captured in DECODE, so the instr bus
  // may change once DECODE has passed.
  always_comb begin
    op_is_stur = (op_q == OP_STUR);
    op_is_ldur = (op_q == OP_LDUR);
    alu_r      = ALU_AND;
    case (op_q)
      OP_ADD:  alu_r = ALU_ADD;
      OP_SUB:  alu_r = ALU_SUB;
      OP_AND:  alu_r = ALU_AND;
      OP_ORR:  alu_r = ALU_ORR;
      default: alu_r = ALU_AND;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    retire     = 1'b0;
    mem_req    = 1'b0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCSrc      = 1'b0;
    reg2loc    = 1'b0;
    AluSrc     = 1'b0;
    memtoReg   = 1'b0;
    regWrite   = 1'b0;
    AluControl = 4'b0000;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        memRead = 1'b1;
        // A completing handshake wins over a watchdog expiry in the same cycle.
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end else if (wd_q == WD_LIMIT) begin
          state_d = S_ERROR;
        end
      end

      S_DECODE: begin
        op_d = instr;
        casez (instr)
          OP_LDUR, OP_STUR:                 state_d = S_ADDR;
          OP_ADD, OP_SUB, OP_AND, OP_ORR:   state_d = S_EXEC_R;
          11'b10110100???:                  state_d = S_BRANCH;
          default:                          state_d = S_ERROR;
        endcase
      end

      S_ADDR: begin
        AluSrc     = 1'b1;
        AluControl = ALU_ADD;
        reg2loc    = op_is_stur;
        state_d    = S_MEMACC;
      end

      S_MEMACC: begin
        mem_req    = 1'b1;
        AluSrc     = 1'b1;
        AluControl = ALU_ADD;
        memRead    = op_is_ldur;
        memWrite   = op_is_stur;
        if (mem_ready) begin
          if (op_is_ldur) begin
            state_d = S_WB_LD;
          end else begin
            // A store has nothing left to write back; it retires here.
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else if (wd_q == WD_LIMIT) begin
          state_d = S_ERROR;
        end
      end

      S_WB_LD: begin
        regWrite = 1'b1;
        memtoReg = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end

      S_EXEC_R: begin
        AluControl = alu_r;
        state_d    = S_WB_R;
      end

      S_WB_R: begin
        regWrite   = 1'b1;
        AluControl = alu_r;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end

      S_BRANCH: begin
        reg2loc    = 1'b1;
        AluControl = ALU_PASSB;
        PCWrite    = zero;
        PCSrc      = zero;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end

      S_ERROR: begin
        state_d = S_ERROR;
      end

      default: begin
        state_d = S_ERROR;
      end
    endcase
  end

  // Watchdog only accumulates while a memory request is outstanding and is
  // cleared on every state change, so each wait is timed independently.
  always_comb begin
    wd_d = wd_q;
    if (state_d != state_q) begin
      wd_d = 8'd0;
    end else if (((state_q == S_FETCH) || (state_q == S_MEMACC)) && !mem_ready) begin
      wd_d = wd_q + 8'd1;
    end
  end

  always_comb begin
    retired_d = retired_q + {15'd0, retire};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      wd_q      <= 8'd0;
      retired_q <= 16'd0;
      op_q      <= 11'd0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      retired_q <= retired_d;
      op_q      <= op_d;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;
  // ERROR is only left through reset, so the state itself holds the flag.
  assign error   = (state_q == S_ERROR);

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [10:0] instr = 11'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, memRead, memWrite, IRWrite, PCWrite, PCSrc;
  logic        reg2loc, AluSrc, memtoReg, regWrite, error;
  logic [3:0]  AluControl, state;
  logic [15:0] retired;

  multicycle_ctrl #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .memRead(memRead), .memWrite(memWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .reg2loc(reg2loc), .AluSrc(AluSrc),
    .memtoReg(memtoReg), .regWrite(regWrite), .AluControl(AluControl),
    .state(state), .retired(retired), .error(error)
  );

  always #5 clk = ~clk;

  localparam logic [10:0] LDUR = 11'b11111000010;
  localparam logic [10:0] STUR = 11'b11111000000;
  localparam logic [10:0] ADD  = 11'b10001011000;
  localparam logic [10:0] SUB  = 11'b11001011000;
  localparam logic [10:0] ANDI = 11'b10001010000;
  localparam logic [10:0] ORR  = 11'b10101010000;
  localparam logic [10:0] CBZ  = 11'b10110100101;
  localparam logic [10:0] ILL  = 11'b00000000000;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_ADDR = 4'd2, S_MEMACC = 4'd3,
                         S_WB_LD = 4'd4, S_EXEC_R = 4'd5, S_WB_R = 4'd6, S_BRANCH = 4'd7,
                         S_ERROR = 4'd8;

  // {mem_req,memRead,memWrite,IRWrite,PCWrite,PCSrc,reg2loc,AluSrc,memtoReg,regWrite,error}
  localparam logic [10:0] C_FW     = 11'b11000000000;
  localparam logic [10:0] C_FR     = 11'b11011000000;
  localparam logic [10:0] C_NONE   = 11'b00000000000;
  localparam logic [10:0] C_ADDR_L = 11'b00000001000;
  localparam logic [10:0] C_ADDR_S = 11'b00000011000;
  localparam logic [10:0] C_MEM_L  = 11'b11000001000;
  localparam logic [10:0] C_MEM_S  = 11'b10100001000;
  localparam logic [10:0] C_WBLD   = 11'b00000000110;
  localparam logic [10:0] C_WBR    = 11'b00000000010;
  localparam logic [10:0] C_BR1    = 11'b00001110000;
  localparam logic [10:0] C_BR0    = 11'b00000010000;
  localparam logic [10:0] C_ERR    = 11'b00000000001;

  typedef struct packed {
    logic        rst;
    logic        chk;
    logic [10:0] instr;
    logic        zero;
    logic        rdy;
    logic [3:0]  st;
    logic [10:0] ctl;
    logic [3:0]  alu;
    logic [15:0] ret;
  } vec_t;

  vec_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_ret = 16'd0;

  function automatic logic [10:0] ctl_obs();
    return {mem_req, memRead, memWrite, IRWrite, PCWrite, PCSrc,
            reg2loc, AluSrc, memtoReg, regWrite, error};
  endfunction

  task automatic push(input logic [10:0] i, input logic z, input logic r,
                      input logic [3:0] st, input logic [10:0] c, input logic [3:0] a);
    vec_t e;
    e.rst = 1'b1; e.chk = 1'b1; e.instr = i; e.zero = z; e.rdy = r;
    e.st = st; e.ctl = c; e.alu = a; e.ret = exp_ret;
    q.push_back(e);
  endtask

  task automatic push_reset(input logic [10:0] i, input logic r);
    vec_t e;
    e = '0;
    e.rst = 1'b0; e.instr = i; e.rdy = r;
    q.push_back(e);
  endtask

  task automatic push_fd(input logic [10:0] i);
    push(i, 1'b0, 1'b1, S_FETCH, C_FR, 4'b0000);
    push(i, 1'b0, 1'b0, S_DECODE, C_NONE, 4'b0000);
  endtask

  task automatic test_reset();
    reset = 1'b0; mem_ready = 1'b0; instr = 11'd0; zero = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (state !== S_FETCH) begin
      errors++; $display("FAIL reset_state: got %0d expected %0d", state, S_FETCH);
    end
    checks++;
    if (ctl_obs() !== C_FW) begin
      errors++; $display("FAIL reset_ctl: got %b expected %b", ctl_obs(), C_FW);
    end
    checks++;
    if (retired !== 16'd0) begin
      errors++; $display("FAIL reset_retired: got %0d expected 0", retired);
    end
    checks++;
    if (AluControl !== 4'b0000) begin
      errors++; $display("FAIL reset_alu: got %b expected 0000", AluControl);
    end
  endtask

  task automatic test_ldur();
    vec_t v;
    push_fd(LDUR);
    push(LDUR, 1'b0, 1'b0, S_ADDR, C_ADDR_L, 4'b0010);
    push(LDUR, 1'b0, 1'b1, S_MEMACC, C_MEM_L, 4'b0010);
    push(LDUR, 1'b0, 1'b0, S_WB_LD, C_WBLD, 4'b0000);
    exp_ret++;
    for (int n = 0; q.size() > 0; n++) begin
      v = q.pop_front();
      @(negedge clk);
      reset = v.rst; instr = v.instr; zero = v.zero; mem_ready = v.rdy;
      #1;
      if (v.chk) begin
        checks++;
        if ({state, ctl_obs(), AluControl, retired} !== {v.st, v.ctl, v.alu, v.ret}) begin
          errors++;
          $display("FAIL ldur step %0d: got st=%0d ctl=%b alu=%b ret=%0d, expected st=%0d ctl=%b alu=%b ret=%0d",
                   n, state, ctl_obs(), AluControl, retired, v.st, v.ctl, v.alu, v.ret);
        end
      end
    end
  endtask

  task automatic test_stur();
    vec_t v;
    push_fd(STUR);
    push(STUR, 1'b0, 1'b0, S_ADDR, C_ADDR_S, 4'b0010);
    for (int k = 0; k < 3; k++) push(STUR, 1'b0, 1'b0, S_MEMACC, C_MEM_S, 4'b0010);
    push(STUR, 1'b0, 1'b1, S_MEMACC, C_MEM_S, 4'b0010);
    exp_ret++;
    for (int n = 0; q.size() > 0; n++) begin
      v = q.pop_front();
      @(negedge clk);
      reset = v.rst; instr = v.instr; zero = v.zero; mem_ready = v.rdy;
      #1;
      if (v.chk) begin
        checks++;
        if ({state, ctl_obs(), AluControl, retired} !== {v.st, v.ctl, v.alu, v.ret}) begin
          errors++;
          $display("FAIL stur step %0d: got st=%0d ctl=%b alu=%b ret=%0d, expected st=%0d ctl=%b alu=%b ret=%0d",
                   n, state, ctl_obs(), AluControl, retired, v.st, v.ctl, v.alu, v.ret);
        end
      end
    end
  endtask

  task automatic test_cbz();
    vec_t v;
    // mem_ready is driven high outside FETCH/MEMACC and must have no effect.
    push(CBZ, 1'b0, 1'b1, S_FETCH, C_FR, 4'b0000);
    push(CBZ, 1'b1, 1'b1, S_DECODE, C_NONE, 4'b0000);
    push(CBZ, 1'b1, 1'b1, S_BRANCH, C_BR1, 4'b0111);
    exp_ret++;
    push_fd(CBZ);
    push(CBZ, 1'b0, 1'b1, S_BRANCH, C_BR0, 4'b0111);
    exp_ret++;
    for (int n = 0; q.size() > 0; n++) begin
      v = q.pop_front();
      @(negedge clk);
      reset = v.rst; instr = v.instr; zero = v.zero; mem_ready = v.rdy;
      #1;
      if (v.chk) begin
        checks++;
        if ({state, ctl_obs(), AluControl, retired} !== {v.st, v.ctl, v.alu, v.ret}) begin
          errors++;
          $display("FAIL cbz step %0d: got st=%0d ctl=%b alu=%b ret=%0d, expected st=%0d ctl=%b alu=%b ret=%0d",
                   n, state, ctl_obs(), AluControl, retired, v.st, v.ctl, v.alu, v.ret);
        end
      end
    end
  endtask

  task automatic test_rtype();
    vec_t v;
    logic [10:0] ops[4];
    logic [3:0]  codes[4];
    logic [10:0] late;
    ops   = '{SUB, ORR, ADD, ANDI};
    codes = '{4'b0110, 4'b0001, 4'b0010, 4'b0000};
    for (int k = 0; k < 4; k++) begin
      // For ORR the instr bus is cleared after DECODE: the captured opcode must rule.
      late = (k == 1) ? ILL : ops[k];
      push_fd(ops[k]);
      push(late, 1'b0, 1'b0, S_EXEC_R, C_NONE, codes[k]);
      push(late, 1'b0, 1'b0, S_WB_R, C_WBR, codes[k]);
      exp_ret++;
    end
    for (int n = 0; q.size() > 0; n++) begin
      v = q.pop_front();
      @(negedge clk);
      reset = v.rst; instr = v.instr; zero = v.zero; mem_ready = v.rdy;
      #1;
      if (v.chk) begin
        checks++;
        if ({state, ctl_obs(), AluControl, retired} !== {v.st, v.ctl, v.alu, v.ret}) begin
          errors++;
          $display("FAIL rtype step %0d: got st=%0d ctl=%b alu=%b ret=%0d, expected st=%0d ctl=%b alu=%b ret=%0d",
                   n, state, ctl_obs(), AluControl, retired, v.st, v.ctl, v.alu, v.ret);
        end
      end
    end
  endtask

  task automatic test_watchdog_boundary();
    vec_t v;
    for (int k = 0; k < 14; k++) push(LDUR, 1'b0, 1'b0, S_FETCH, C_FW, 4'b0000);
    push_fd(LDUR);
    push(LDUR, 1'b0, 1'b0, S_ADDR, C_ADDR_L, 4'b0010);
    for (int k = 0; k < 14; k++) push(LDUR, 1'b0, 1'b0, S_MEMACC, C_MEM_L, 4'b0010);
    push(LDUR, 1'b0, 1'b1, S_MEMACC, C_MEM_L, 4'b0010);
    push(LDUR, 1'b0, 1'b0, S_WB_LD, C_WBLD, 4'b0000);
    exp_ret++;
    for (int n = 0; q.size() > 0; n++) begin
      v = q.pop_front();
      @(negedge clk);
      reset = v.rst; instr = v.instr; zero = v.zero; mem_ready = v.rdy;
      #1;
      if (v.chk) begin
        checks++;
        if ({state, ctl_obs(), AluControl, retired} !== {v.st, v.ctl, v.alu, v.ret}) begin
          errors++;
          $display("FAIL wd_boundary step %0d: got st=%0d ctl=%b alu=%b ret=%0d, expected st=%0d ctl=%b alu=%b ret=%0d",
                   n, state, ctl_obs(), AluControl, retired, v.st, v.ctl, v.alu, v.ret);
        end
      end
    end
  endtask

  task automatic test_illegal();
    vec_t v;
    push(ILL, 1'b0, 1'b1, S_FETCH, C_FR, 4'b0000);
    push(ILL, 1'b0, 1'b0, S_DECODE, C_NONE, 4'b0000);
    for (int k = 0; k < 20; k++) push(ILL, 1'b0, 1'(k % 2), S_ERROR, C_ERR, 4'b0000);
    push_reset(ILL, 1'b0);
    exp_ret = 16'd0;
    push_fd(ADD);
    push(ADD, 1'b0, 1'b0, S_EXEC_R, C_NONE, 4'b0010);
    push(ADD, 1'b0, 1'b0, S_WB_R, C_WBR, 4'b0010);
    exp_ret++;
    for (int n = 0; q.size() > 0; n++) begin
      v = q.pop_front();
      @(negedge clk);
      reset = v.rst; instr = v.instr; zero = v.zero; mem_ready = v.rdy;
      #1;
      if (v.chk) begin
        checks++;
        if ({state, ctl_obs(), AluControl, retired} !== {v.st, v.ctl, v.alu, v.ret}) begin
          errors++;
          $display("FAIL illegal step %0d: got st=%0d ctl=%b alu=%b ret=%0d, expected st=%0d ctl=%b alu=%b ret=%0d",
                   n, state, ctl_obs(), AluControl, retired, v.st, v.ctl, v.alu, v.ret);
        end
      end
    end
  endtask

  task automatic test_watchdog_timeout();
    vec_t v;
    for (int k = 0; k < 15; k++) push(ADD, 1'b0, 1'b0, S_FETCH, C_FW, 4'b0000);
    for (int k = 0; k < 3; k++) push(ADD, 1'b0, 1'b1, S_ERROR, C_ERR, 4'b0000);
    push_reset(ADD, 1'b0);
    exp_ret = 16'd0;
    push(ADD, 1'b0, 1'b0, S_FETCH, C_FW, 4'b0000);
    for (int n = 0; q.size() > 0; n++) begin
      v = q.pop_front();
      @(negedge clk);
      reset = v.rst; instr = v.instr; zero = v.zero; mem_ready = v.rdy;
      #1;
      if (v.chk) begin
        checks++;
        if ({state, ctl_obs(), AluControl, retired} !== {v.st, v.ctl, v.alu, v.ret}) begin
          errors++;
          $display("FAIL wd_timeout step %0d: got st=%0d ctl=%b alu=%b ret=%0d, expected st=%0d ctl=%b alu=%b ret=%0d",
                   n, state, ctl_obs(), AluControl, retired, v.st, v.ctl, v.alu, v.ret);
        end
      end
    end
  endtask

  task automatic test_reset_mid_memacc();
    vec_t v;
    push_fd(STUR);
    push(STUR, 1'b0, 1'b0, S_ADDR, C_ADDR_S, 4'b0010);
    push(STUR, 1'b0, 1'b0, S_MEMACC, C_MEM_S, 4'b0010);
    push(STUR, 1'b0, 1'b0, S_MEMACC, C_MEM_S, 4'b0010);
    // Store completes on the reset edge: reset wins, nothing retires.
    push_reset(STUR, 1'b1);
    for (int k = 0; k < 14; k++) push(SUB, 1'b0, 1'b0, S_FETCH, C_FW, 4'b0000);
    push_fd(SUB);
    push(SUB, 1'b0, 1'b0, S_EXEC_R, C_NONE, 4'b0110);
    push(SUB, 1'b0, 1'b0, S_WB_R, C_WBR, 4'b0110);
    exp_ret++;
    push(SUB, 1'b0, 1'b0, S_FETCH, C_FW, 4'b0000);
    for (int n = 0; q.size() > 0; n++) begin
      v = q.pop_front();
      @(negedge clk);
      reset = v.rst; instr = v.instr; zero = v.zero; mem_ready = v.rdy;
      #1;
      if (v.chk) begin
        checks++;
        if ({state, ctl_obs(), AluControl, retired} !== {v.st, v.ctl, v.alu, v.ret}) begin
          errors++;
          $display("FAIL reset_memacc step %0d: got st=%0d ctl=%b alu=%b ret=%0d, expected st=%0d ctl=%b alu=%b ret=%0d",
                   n, state, ctl_obs(), AluControl, retired, v.st, v.ctl, v.alu, v.ret);
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL time_limit: simulation still running at %0t, expected completion", $time);
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_ldur();
    test_stur();
    test_cbz();
    test_rtype();
    test_watchdog_boundary();
    test_illegal();
    test_watchdog_timeout();
    test_reset_mid_memacc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
